eem16_coin_tx: RTL

EEM16_COIN_TX -- requirements
Module: eem16_coin_tx

---
 rtl/eem16_coin_tx.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/eem16_coin_tx.sv
// eem16_coin_tx: pays out a requested amount, given in nickels, as a stream of
// coin codes on x. The block uses as many dimes as it can, and a nickel for any
// odd remainder.
//
// A payout starts in IDLE. Each coin is held on x for one cycle. An optional
// run of GAP idle cycles separates one coin from the next. The payout always
// ends with a one-cycle DONE, where the done output pulses. An abort ends the
// payout early: the next cycle is DONE with aborted set.
//
// Parameters
//   GAP         idle cycles (x=0) between consecutive coins, 0..7
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   req_valid   request present
//   req_amt     payout amount in nickels, sampled on accept
//   req_ready   high only in IDLE
//   abort       end the payout in progress (ignored in IDLE/DONE)
//   x           registered coin code: 00 none, 01 nickel, 11 dime
//   busy        high in SEND, GAP and DONE
//   done        one-cycle completion pulse
//   aborted     qualifies done when the payout was cut short
//   coins_sent  coin codes emitted for the current or last request
module eem16_coin_tx #(
    parameter int unsigned GAP = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [4:0] req_amt,
    output logic       req_ready,
    input  logic       abort,
    output logic [1:0] x,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic [4:0] coins_sent
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

    localparam logic [2:0] GAP_LOAD = (GAP > 0) ? 3'(GAP - 1) : 3'd0;

    state_t     state, state_nxt;
    logic [4:0] rem;
    logic [2:0] gap_cnt;
    logic       aborted_q;

    // Decisions made by the next-state logic.
    // emit:      a coin appears on x in the next cycle.
    // src:       the amount that coin is taken from.
    // kill:      the payout was aborted.
    // enter_gap: load the gap counter.
    logic       accept, emit, kill, enter_gap;
    logic [4:0] src;
    logic [1:0] coin_code;
    logic [4:0] coin_step;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        emit      = 1'b0;
        kill      = 1'b0;
        enter_gap = 1'b0;
        src       = rem;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    src    = req_amt;
                    if (req_amt != 5'd0) begin
                        emit      = 1'b1;
                        state_nxt = S_SEND;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_SEND: begin
                // Abort is checked before the "last coin" exit, so an abort
                // that arrives with the final coin still reports aborted.
                if (abort) begin
                    kill      = 1'b1;
                    state_nxt = S_DONE;
                end else if (rem == 5'd0) begin
                    state_nxt = S_DONE;
                end else if (GAP == 0) begin
                    emit      = 1'b1;
                    state_nxt = S_SEND;
                end else begin
                    enter_gap = 1'b1;
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (abort) begin
                    kill      = 1'b1;
                    state_nxt = S_DONE;
                end else if (gap_cnt == 3'd0) begin
                    emit      = 1'b1;
                    state_nxt = S_SEND;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Greedy coin choice: a dime when at least two nickels remain.
    assign coin_code = (src >= 5'd2) ? 2'b11 : 2'b01;
    assign coin_step = (src >= 5'd2) ? 5'd2  : 5'd1;

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x          <= 2'b00;
            rem        <= 5'd0;
            coins_sent <= 5'd0;
            gap_cnt    <= 3'd0;
            aborted_q  <= 1'b0;
        end else begin
            x <= emit ? coin_code : 2'b00;

            if (kill)        rem <= 5'd0;
            else if (emit)   rem <= src - coin_step;
            else if (accept) rem <= 5'd0;

            // On accept the count restarts. It is 1 if the first coin is
            // emitted right away, and 0 for a zero-amount request.
            if (accept)    coins_sent <= {4'd0, emit};
            else if (emit) coins_sent <= coins_sent + 5'd1;

            if (enter_gap)
                gap_cnt <= GAP_LOAD;
            else if (state == S_GAP && gap_cnt != 3'd0)
                gap_cnt <= gap_cnt - 3'd1;

            // Set only on the edge into DONE. It clears on the edge that leaves DONE.
            aborted_q <= kill;
        end
    end

    // Outputs
    always_comb begin
        req_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        aborted   = aborted_q;
    end

endmodule
